// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns pipeline MemRead/MemWrite requests into handshaked word-aligned memory transactions.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses; otherwise they are rounded down and executed.
module lsu_mem_initiator #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t state_q, state_d;

    logic                  is_load_q;
    logic                  unsigned_q;
    size_t                 size_q;
    logic [1:0]            off_q;
    logic [DATA_W-1:0]     rd_q;
    logic                  req_valid_q;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [3:0]            wstrb_q;
    logic [DATA_W-1:0]     wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  mis_q;
`endif

    logic                  op_req;
    size_t                 size_n;
    logic                  mis_n;
    logic                  trap_n;
    logic [1:0]            off_n;
    logic [3:0]            strb_n;
    logic [DATA_W-1:0]     wdata_n;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     load_n;

    // Decode the incoming request; loads and stores map unknown Funct3 codes to a full word.
    always_comb begin
        op_req = MemRead | MemWrite;
        size_n = SZ_W;
        if (MemRead) begin
            case (Funct3)
                3'b000, 3'b100: size_n = SZ_B;
                3'b001, 3'b101: size_n = SZ_H;
                default:        size_n = SZ_W;
            endcase
        end else begin
            case (Funct3)
                3'b000:  size_n = SZ_B;
                3'b001:  size_n = SZ_H;
                default: size_n = SZ_W;
            endcase
        end
        mis_n = ((size_n == SZ_H) && a[0]) || ((size_n == SZ_W) && (a[1:0] != 2'b00));
        off_n = a[1:0];
        if (size_n == SZ_W) off_n = 2'b00;
        if (size_n == SZ_H) off_n[0] = 1'b0;
        case (size_n)
            SZ_B:    strb_n = 4'b0001 << off_n;
            SZ_H:    strb_n = 4'b0011 << off_n;
            default: strb_n = 4'b1111;
        endcase
        wdata_n = wd << {off_n, 3'b000};
        if (MemRead) begin
            strb_n  = 4'b0000;
            wdata_n = '0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_n = mis_n;
`else
    assign trap_n = 1'b0;
`endif

    // Word accesses always have off_q == 0, so the shifted word is the raw word.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_B:    load_n = unsigned_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                         : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            SZ_H:    load_n = unsigned_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                         : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            default: load_n = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = op_req;
                if (op_req) state_d = trap_n ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (mem_req_ready) state_d = is_load_q ? WAIT : DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rsp_valid) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall = stall & rst_n;
    end

    // Request fields are captured once on acceptance and held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q   <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= SZ_W;
            off_q       <= 2'b00;
            rd_q        <= '0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            req_valid_q <= (state_d == REQ);
            if (state_q == IDLE && op_req) begin
                is_load_q  <= MemRead;
                unsigned_q <= Funct3[2];
                size_q     <= size_n;
                off_q      <= off_n;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q      <= trap_n;
`endif
                if (!trap_n) begin
                    we_q    <= ~MemRead;
                    addr_q  <= {a[DM_ADDRESS-1:2], 2'b00};
                    wstrb_q <= strb_n;
                    wdata_q <= wdata_n;
                end
            end
            if (state_q == WAIT && mem_rsp_valid) rd_q <= load_n;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = done & mis_q;
`else
    assign misaligned = 1'b0;
`endif

    assign rd            = rd_q;
    assign mem_req_valid = req_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wstrb     = wstrb_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator with a small handshaking memory responder.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it defined.
module tb_lsu_mem_initiator;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    int          readyDelay  = 0;
    int          waitCnt     = 0;
    bit          suppressRsp = 0;
    bit          forceRsp    = 0;
    bit          hsPend;
    bit          wePend;
    logic [31:0] rspData     = 32'h0;

    int          opIters;
    bit          opDone;
    int          reqCycles;
    bit          reqUnstable;
    bit          stallDrop;
    bit          doneStall;
    bit          doneMis;
    logic [31:0] doneRd;
    logic [8:0]  reqAddr;
    logic [3:0]  reqStrb;
    logic [31:0] reqWdata;
    logic        reqWe;
    logic [31:0] expRd = 32'h0;

    lsu_mem_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .a(a), .wd(wd), .rd(rd), .stall(stall), .done(done),
        .misaligned(misaligned), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ready after readyDelay request cycles, read data the cycle after a load handshake.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
    end
    always begin
        @(negedge clk);
        hsPend = mem_req_valid && mem_req_ready && rst_n;
        wePend = mem_we;
        @(posedge clk);
        #2;
        mem_rsp_valid = (hsPend && !wePend && !suppressRsp) || forceRsp;
        mem_rdata     = rspData;
        if (mem_req_valid) begin
            mem_req_ready = (waitCnt >= readyDelay);
            waitCnt++;
        end else begin
            mem_req_ready = 1'b0;
            waitCnt = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic startOp(input bit rdOp, input bit wrOp, input logic [2:0] f3,
                           input logic [8:0] addr, input logic [31:0] data);
        MemRead  = rdOp;
        MemWrite = wrOp;
        Funct3   = f3;
        a        = addr;
        wd       = data;
    endtask

    task automatic idleTick();
        @(posedge clk);
        #1;
    endtask

    // Observes one transaction until done, recording request fields, stall and completion values.
    task automatic runUntilDone(input int bound);
        opIters = 0; opDone = 0; reqCycles = 0; reqUnstable = 0; stallDrop = 0;
        doneStall = 0; doneMis = 0; doneRd = 32'h0;
        reqAddr = 9'h0; reqStrb = 4'h0; reqWdata = 32'h0; reqWe = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            opIters++;
            if (done) begin
                opDone    = 1;
                doneStall = stall;
                doneMis   = misaligned;
                doneRd    = rd;
                MemRead   = 1'b0;
                MemWrite  = 1'b0;
                break;
            end
            if (!stall) stallDrop = 1;
            if (mem_req_valid) begin
                if (reqCycles == 0) begin
                    reqAddr = mem_addr; reqStrb = mem_wstrb; reqWdata = mem_wdata; reqWe = mem_we;
                end else if (mem_addr !== reqAddr || mem_wstrb !== reqStrb ||
                             mem_wdata !== reqWdata || mem_we !== reqWe) begin
                    reqUnstable = 1;
                end
                reqCycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        startOp(1, 0, 3'b010, 9'h010, 32'h0);
        #12;
        checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall: got %b want 0", stall); end
        checks++; if (done !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("[TB] FAIL rst_done: got %b%b want 00", done, misaligned); end
        checks++; if (mem_req_valid !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b%b want 00", mem_req_valid, mem_we); end
        checks++; if (mem_addr !== 9'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_fields: got %h %h %h want 0", mem_addr, mem_wstrb, mem_wdata); end
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL rst_rd: got %h want 0", rd); end
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleTick();
    endtask

    task automatic test_store();
        startOp(0, 1, 3'b010, 9'h010, 32'hDEADBEEF);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("[TB] FAIL sw_idle_stall: got %b want 1", stall); end
        runUntilDone(10);
        checks++; if (!opDone || opIters + 1 != 3) begin failures++; $display("[TB] FAIL sw_latency: got %0d (done=%0d) want 3", opIters + 1, opDone); end
        checks++; if (reqAddr !== 9'h010 || reqStrb !== 4'b1111 || reqWe !== 1'b1) begin failures++; $display("[TB] FAIL sw_req: got addr=%h strb=%b we=%b want 010 1111 1", reqAddr, reqStrb, reqWe); end
        checks++; if (reqWdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL sw_wdata: got %h want deadbeef", reqWdata); end
        checks++; if (doneStall !== 1'b0 || doneMis !== 1'b0) begin failures++; $display("[TB] FAIL sw_done_flags: got stall=%b mis=%b want 0 0", doneStall, doneMis); end
        checks++; if (doneRd !== expRd) begin failures++; $display("[TB] FAIL sw_rd_kept: got %h want %h", doneRd, expRd); end
        idleTick();
        checks++; if (done !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL sw_pulse: got done=%b valid=%b want 0 0", done, mem_req_valid); end

        startOp(0, 1, 3'b000, 9'h013, 32'h000000A5);
        runUntilDone(10);
        checks++; if (!opDone || opIters + 1 != 3 || reqAddr !== 9'h010 || reqStrb !== 4'b1000) begin failures++; $display("[TB] FAIL sb_req: got lat=%0d addr=%h strb=%b want 3 010 1000", opIters + 1, reqAddr, reqStrb); end
        checks++; if (reqWdata[31:24] !== 8'hA5) begin failures++; $display("[TB] FAIL sb_wdata: got %h want a5", reqWdata[31:24]); end
        idleTick();

        startOp(0, 1, 3'b001, 9'h012, 32'h00001234);
        runUntilDone(10);
        checks++; if (!opDone || reqAddr !== 9'h010 || reqStrb !== 4'b1100 || reqWdata[31:16] !== 16'h1234) begin failures++; $display("[TB] FAIL sh_req: got addr=%h strb=%b data=%h want 010 1100 1234", reqAddr, reqStrb, reqWdata[31:16]); end
        idleTick();
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3Tab   [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b000, 3'b010, 3'b111};
        logic [8:0]  addrTab [8] = '{9'h013, 9'h013, 9'h012, 9'h012, 9'h010, 9'h011, 9'h014, 9'h018};
        logic [31:0] expTab  [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                                     32'h00007F01, 32'h0000007F, 32'h80FF7F01, 32'h80FF7F01};
        logic [8:0]  wordAddr;
        rspData = 32'h80FF7F01;
        for (int k = 0; k < 8; k++) begin
            startOp(1, 0, f3Tab[k], addrTab[k], 32'h0);
            runUntilDone(10);
            expRd    = expTab[k];
            wordAddr = {addrTab[k][8:2], 2'b00};
            checks++; if (!opDone || doneRd !== expRd) begin failures++; $display("[TB] FAIL load_rd[%0d]: got %h want %h", k, doneRd, expRd); end
            checks++; if (opIters + 1 != 4 || reqAddr !== wordAddr || reqWe !== 1'b0) begin failures++; $display("[TB] FAIL load_req[%0d]: got lat=%0d addr=%h we=%b want 4 %h 0", k, opIters + 1, reqAddr, reqWe, wordAddr); end
            idleTick();
        end
    endtask

    task automatic test_ready_stall();
        readyDelay = 5;
        rspData    = 32'h12345678;
        startOp(1, 0, 3'b010, 9'h020, 32'h0);
        runUntilDone(30);
        expRd = 32'h12345678;
        checks++; if (reqCycles != 6 || reqUnstable) begin failures++; $display("[TB] FAIL rdy_hold: got cycles=%0d unstable=%0d want 6 0", reqCycles, reqUnstable); end
        checks++; if (stallDrop) begin failures++; $display("[TB] FAIL rdy_stall: got stall drop want none"); end
        checks++; if (!opDone || opIters + 1 != 9 || doneRd !== expRd || reqAddr !== 9'h020) begin failures++; $display("[TB] FAIL rdy_result: got lat=%0d rd=%h addr=%h want 9 %h 020", opIters + 1, doneRd, reqAddr, expRd); end
        readyDelay = 0;
        idleTick();
    endtask

    task automatic test_misaligned();
        rspData = 32'h55AA33CC;
        startOp(1, 0, 3'b010, 9'h006, 32'h0);
        runUntilDone(10);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (!opDone || opIters + 1 != 2 || doneMis !== 1'b1) begin failures++; $display("[TB] FAIL lw_trap: got lat=%0d mis=%b want 2 1", opIters + 1, doneMis); end
        checks++; if (reqCycles != 0 || doneRd !== expRd) begin failures++; $display("[TB] FAIL lw_trap_side: got req=%0d rd=%h want 0 %h", reqCycles, doneRd, expRd); end
        idleTick();
        checks++; if (misaligned !== 1'b0) begin failures++; $display("[TB] FAIL lw_trap_pulse: got %b want 0", misaligned); end
`else
        expRd = 32'h55AA33CC;
        checks++; if (!opDone || opIters + 1 != 4 || reqAddr !== 9'h004) begin failures++; $display("[TB] FAIL lw_round: got lat=%0d addr=%h want 4 004", opIters + 1, reqAddr); end
        checks++; if (doneRd !== expRd || doneMis !== 1'b0) begin failures++; $display("[TB] FAIL lw_round_rd: got rd=%h mis=%b want %h 0", doneRd, doneMis, expRd); end
        idleTick();
`endif
        startOp(0, 1, 3'b001, 9'h011, 32'h0000BEEF);
        runUntilDone(10);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (!opDone || opIters + 1 != 2 || doneMis !== 1'b1 || reqCycles != 0) begin failures++; $display("[TB] FAIL sh_trap: got lat=%0d mis=%b req=%0d want 2 1 0", opIters + 1, doneMis, reqCycles); end
`else
        checks++; if (!opDone || reqAddr !== 9'h010 || reqStrb !== 4'b0011 || reqWdata[15:0] !== 16'hBEEF) begin failures++; $display("[TB] FAIL sh_round: got addr=%h strb=%b data=%h want 010 0011 beef", reqAddr, reqStrb, reqWdata[15:0]); end
`endif
        idleTick();
    endtask

    task automatic test_back_to_back();
        rspData = 32'h0BADF00D;
        startOp(0, 1, 3'b010, 9'h030, 32'h11223344);
        runUntilDone(10);
        checks++; if (!opDone || opIters + 1 != 3 || doneStall !== 1'b0) begin failures++; $display("[TB] FAIL b2b_store: got lat=%0d stall=%b want 3 0", opIters + 1, doneStall); end
        startOp(1, 0, 3'b010, 9'h030, 32'h0);
        runUntilDone(10);
        expRd = 32'h0BADF00D;
        checks++; if (!opDone || opIters != 4 || doneRd !== expRd || reqWe !== 1'b0) begin failures++; $display("[TB] FAIL b2b_load: got iters=%0d rd=%h we=%b want 4 %h 0", opIters, doneRd, reqWe, expRd); end
        idleTick();
    endtask

    task automatic test_reset_mid();
        bit doneSeen;
        readyDelay = 100;
        startOp(0, 1, 3'b010, 9'h040, 32'hA5A5A5A5);
        idleTick();
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstreq_valid: got %b want 1", mem_req_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("[TB] FAIL rstreq_drop: got valid=%b stall=%b want 0 0", mem_req_valid, stall); end
        MemWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        readyDelay = 0;
        idleTick();
        expRd = 32'h0;
        checks++; if (mem_req_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rstreq_noretry: got valid=%b done=%b want 0 0", mem_req_valid, done); end

        suppressRsp = 1;
        rspData = 32'hCAFEF00D;
        startOp(1, 0, 3'b010, 9'h050, 32'h0);
        idleTick();
        idleTick();
        checks++; if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_state: got stall=%b valid=%b want 1 0", stall, mem_req_valid); end
        rst_n = 1'b0;
        #1;
        MemRead = 1'b0;
        checks++; if (stall !== 1'b0 || done !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL rstwait_reset: got stall=%b done=%b rd=%h want 0 0 0", stall, done, rd); end
        @(negedge clk);
        rst_n = 1'b1;
        suppressRsp = 0;
        forceRsp = 1;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            idleTick();
            if (done) doneSeen = 1;
        end
        forceRsp = 0;
        checks++; if (doneSeen) begin failures++; $display("[TB] FAIL rstwait_stray: got done pulse want none"); end
        checks++; if (rd !== expRd || stall !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_idle: got rd=%h stall=%b valid=%b want 0 0 0", rd, stall, mem_req_valid); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_extract();
        test_ready_stall();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
